div_iter: RTL



---
 rtl/alu_pkg.sv | 19 +
 rtl/div_step.sv | 79 +++++++
 rtl/div_iter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the MiniSys-1A ALU HI/LO path.
//   WIDTH       : operand/result width of the divider
//   ITER_COUNT  : restoring steps per divide (one per quotient bit)
//   CNT_W       : width of the iteration counter
//   div_state_t : divider FSM encoding (IDLE=0, ITER=1, FIX=2, DONE=3)
package alu_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   i_rem  : current partial remainder (always < i_dvs)
//   i_dvd  : dividend shift register; its MSB is the next numerator bit
//   i_dvs  : divisor magnitude
//   o_rem  : partial remainder after this step
//   o_dvd  : dividend register shifted left with the quotient bit at the LSB
//   o_qbit : quotient bit produced by this step (1 = no borrow)
// The trial subtraction rem_shift - dvs is done as rem_shift + ~dvs + 1 in
// WIDTH+1 bits on a 4-bit-group carry-lookahead adder; carry-out 1 means
// no borrow.
module div_step #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dvd,
  output logic             o_qbit
);

  localparam int N  = WIDTH + 1;
  localparam int NB = (N + 3) / 4;

  // The shifted remainder keeps the bit that leaves rem[WIDTH-1]; with a
  // divisor >= 2^(WIDTH-1) the shifted value can exceed WIDTH bits, and
  // dropping it would corrupt large unsigned divides.
  logic [N-1:0]  w_rem_shift;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic [N-1:0]  w_p;
  logic [N-1:0]  w_g;
  logic [N-1:0]  w_s;
  logic [NB-1:0] w_gg;
  logic [NB-1:0] w_gp;
  logic [NB:0]   w_gc;
  logic          w_bc;
  logic          w_cout;
  logic          w_unused_msb;

  assign w_rem_shift = {i_rem, i_dvd[WIDTH-1]};
  assign w_a         = w_rem_shift;
  assign w_b         = ~{1'b0, i_dvs};

  always_comb begin
    w_p  = w_a ^ w_b;
    w_g  = w_a & w_b;
    w_gg = '0;
    w_gp = '1;
    // Group generate/propagate, bits visited LSB-first inside each group.
    for (int i = 0; i < N; i++) begin
      w_gg[i/4] = w_g[i] | (w_p[i] & w_gg[i/4]);
      w_gp[i/4] = w_gp[i/4] & w_p[i];
    end
    // Lookahead across groups; carry-in 1 completes the two's complement.
    w_gc[0] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      w_gc[b+1] = w_gg[b] | (w_gp[b] & w_gc[b]);
    end
    // Ripple only inside a group, seeded by the group carry.
    w_bc = 1'b0;
    w_s  = '0;
    for (int i = 0; i < N; i++) begin
      if ((i % 4) == 0) w_bc = w_gc[i/4];
      w_s[i] = w_p[i] ^ w_bc;
      w_bc   = w_g[i] | (w_p[i] & w_bc);
    end
    w_cout = w_gc[NB];
  end

  // With no borrow the difference is below dvs, so its top bit is zero.
  assign w_unused_msb = w_s[N-1];

  assign o_qbit = w_cout;
  assign o_rem  = w_cout ? w_s[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
  assign o_dvd  = {i_dvd[WIDTH-2:0], w_cout};

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV / DIVU (quotient to LO, remainder to HI).
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : request, accepted only in IDLE
//   is_signed    : 1 = two's-complement divide, 0 = unsigned
//   dividend     : numerator, sampled with start
//   divisor      : denominator, sampled with start
//   busy         : high in ITER and FIX
//   done         : one-cycle pulse, results valid
//   quotient     : result to LO
//   remainder    : result to HI (sign of dividend, or zero)
//   div_by_zero  : set with results when the divisor was zero
// Latency: start at edge E0, 32 ITER edges, FIX at E33, done in the cycle
// after E33. A zero divisor skips straight to DONE (done after E0).
module div_iter #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import alu_pkg::*;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic             sgn);
    return (sgn && v[WIDTH-1]) ? f_neg(v) : v;
  endfunction

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;
  logic             w_qbit;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_dvs_zero = (divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_dvd  (r_dvd),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_dvd  (w_dvd_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = w_dvs_zero ? DONE : ITER;
      ITER: if (r_cnt == LAST_ITER) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control and visible results: cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        r_dbz <= w_dvs_zero;
        // A zero divisor publishes its results immediately; the remainder
        // is the dividend exactly as presented, never its magnitude.
        if (w_dvs_zero) begin
          r_quot <= '1;
          r_remo <= dividend;
        end
      end else if (r_state == ITER) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == FIX) begin
        r_quot <= r_qneg ? f_neg(r_dvd) : r_dvd;
        r_remo <= r_rneg ? f_neg(r_rem) : r_rem;
      end
    end
  end

  // Working datapath: no reset, only loaded on an accepted start.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_dvd  <= f_mag(dividend, is_signed);
      r_dvs  <= f_mag(divisor, is_signed);
      r_rem  <= '0;
      r_qneg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_rneg <= is_signed & dividend[WIDTH-1];
    end else if (r_state == ITER) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_dvd_nxt;
    end
  end

  assign busy        = (r_state == ITER) || (r_state == FIX);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

  // Quotient bit is already folded into w_dvd_nxt by the step.
  logic w_unused_qbit;
  assign w_unused_qbit = w_qbit;

endmodule
